// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result and ALU-side signals of alu_seq.
interface alu_seq_if #(parameter int WIDTH = 16, parameter int AMT_W = 4);
  logic             i_req;
  logic             i_dir;
  logic [AMT_W-1:0] i_amount;
  logic [WIDTH-1:0] i_data;
  logic             o_ready;
  logic             o_done;
  logic [WIDTH-1:0] o_data;
  logic [3:0]       o_alu_op;
  logic [WIDTH-1:0] o_alu_arg0;
  logic [WIDTH-1:0] o_alu_arg1;
  logic [WIDTH-1:0] i_alu_data;
  modport slave (
    input  i_req, i_dir, i_amount, i_data, i_alu_data,
    output o_ready, o_done, o_data, o_alu_op, o_alu_arg0, o_alu_arg1
  );
  modport master (
    output i_req, i_dir, i_amount, i_data, i_alu_data,
    input  o_ready, o_done, o_data, o_alu_op, o_alu_arg0, o_alu_arg1
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-step rotate-left / arithmetic-shift-right sequenced through an external registered ALU.
// ALU_SEQ_ROL8_EN allows 8-bit rotate steps; without it rotates step at most 4.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  alu_seq_if.slave   bus
);
  localparam logic [3:0] NO_OP   = 4'd0;
  localparam logic [3:0] ROL_OP  = 4'd1;
  localparam logic [3:0] ROL2_OP = 4'd2;
  localparam logic [3:0] ROL4_OP = 4'd3;
  localparam logic [3:0] ROL8_OP = 4'd4;
  localparam logic [3:0] ASR_OP  = 4'd5;
  localparam logic [3:0] ASR2_OP = 4'd6;
  localparam logic [3:0] ASR4_OP = 4'd7;
`ifdef ALU_SEQ_ROL8_EN
  localparam logic ROL8 = 1'b1;
`else
  localparam logic ROL8 = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_data_q, r_data_d, o_data_q;
  logic [AMT_W-1:0] r_rem_q, r_rem_d, step;
  logic             r_dir_q, r_dir_d, o_done_q;
  logic [3:0]       step_op;
  always_comb begin
    step = (ROL8 && !r_dir_q && r_rem_q >= AMT_W'(8)) ? AMT_W'(8) :
           r_rem_q >= AMT_W'(4) ? AMT_W'(4) :
           r_rem_q >= AMT_W'(2) ? AMT_W'(2) : AMT_W'(1);
    step_op = r_dir_q ? (step == AMT_W'(4) ? ASR4_OP : step == AMT_W'(2) ? ASR2_OP : ASR_OP) :
              (step == AMT_W'(8) ? ROL8_OP : step == AMT_W'(4) ? ROL4_OP :
               step == AMT_W'(2) ? ROL2_OP : ROL_OP);
  end
  always_comb begin
    state_d  = state_q;
    r_data_d = r_data_q;
    r_rem_d  = r_rem_q;
    r_dir_d  = r_dir_q;
    case (state_q)
      IDLE: if (bus.i_req) begin
        r_data_d = bus.i_data;
        r_rem_d  = bus.i_amount;
        r_dir_d  = bus.i_dir;
        state_d  = bus.i_amount == '0 ? DONE : ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        r_data_d = bus.i_alu_data;
        r_rem_d  = r_rem_q - step;
        state_d  = r_rem_q == step ? DONE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end
  // result and done are registered on entry to DONE so they are visible during the DONE cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      r_data_q <= '0;
      r_rem_q  <= '0;
      r_dir_q  <= 1'b0;
      o_data_q <= '0;
      o_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_data_q <= r_data_d;
      r_rem_q  <= r_rem_d;
      r_dir_q  <= r_dir_d;
      o_data_q <= state_d == DONE ? r_data_d : o_data_q;
      o_done_q <= state_d == DONE;
    end
  end
  assign bus.o_ready    = state_q == IDLE;
  assign bus.o_done     = o_done_q;
  assign bus.o_data     = o_data_q;
  assign bus.o_alu_op   = state_q == ISSUE ? step_op : NO_OP;
  assign bus.o_alu_arg0 = r_data_q;
  assign bus.o_alu_arg1 = '0;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq against a behavioural registered ALU.
module tb_alu_seq;
  localparam logic [3:0] NO_OP = 4'd0, ROL_OP = 4'd1, ROL2_OP = 4'd2, ROL4_OP = 4'd3,
                         ROL8_OP = 4'd4, ASR_OP = 4'd5, ASR2_OP = 4'd6, ASR4_OP = 4'd7;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] alu_q = 16'h0;
  int tests = 0;
  int fails = 0;
  alu_seq_if #(.WIDTH(16), .AMT_W(4)) bus ();
  alu_seq #(.WIDTH(16), .AMT_W(4)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] rol(input logic [15:0] a, input int n);
    return (a << n) | (a >> (16 - n));
  endfunction
  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a);
    case (op)
      ROL_OP:  return rol(a, 1);
      ROL2_OP: return rol(a, 2);
      ROL4_OP: return rol(a, 4);
      ROL8_OP: return rol(a, 8);
      ASR_OP:  return 16'($signed(a) >>> 1);
      ASR2_OP: return 16'($signed(a) >>> 2);
      ASR4_OP: return 16'($signed(a) >>> 4);
      default: return 16'hDEAD;
    endcase
  endfunction
  always_ff @(posedge clk) alu_q <= alu_f(bus.o_alu_op, bus.o_alu_arg0);
  assign bus.i_alu_data = alu_q;
  task automatic run_op(input string nm, input logic d, input logic [3:0] amt, input logic [15:0] din,
                        input logic [15:0] dexp, input int k, input logic [31:0] ops_exp, input int pulse_at);
    int done_at = 0, dones = 0, rdy_at = 0;
    logic [31:0] ops = 32'h0;
    bus.i_req = 1'b1; bus.i_dir = d; bus.i_amount = amt; bus.i_data = din;
    @(posedge clk); #1;
    bus.i_req = 1'b0; bus.i_dir = ~d; bus.i_amount = 4'hF; bus.i_data = 16'h5555;
    for (int n = 1; n <= 2 * k + 4; n++) begin
      if (bus.o_alu_op !== NO_OP) ops = {ops[27:0], bus.o_alu_op};
      if (bus.o_done === 1'b1) begin dones++; if (done_at == 0) done_at = n; end
      if (bus.o_ready === 1'b1 && rdy_at == 0) rdy_at = n;
      bus.i_req = n == pulse_at;
      bus.i_data = n == pulse_at ? 16'hAAAA : 16'h5555;
      @(posedge clk); #1;
    end
    bus.i_req = 1'b0;
    tests++; if (done_at !== 2 * k + 1) begin fails++; $display("FAIL %s done_cycle: got %0d expected %0d", nm, done_at, 2 * k + 1); end
    tests++; if (dones !== 1) begin fails++; $display("FAIL %s done_pulses: got %0d expected 1", nm, dones); end
    tests++; if (rdy_at !== 2 * k + 2) begin fails++; $display("FAIL %s ready_cycle: got %0d expected %0d", nm, rdy_at, 2 * k + 2); end
    tests++; if (bus.o_data !== dexp) begin fails++; $display("FAIL %s data: got %h expected %h", nm, bus.o_data, dexp); end
    tests++; if (ops !== ops_exp) begin fails++; $display("FAIL %s ops: got %h expected %h", nm, ops, ops_exp); end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL reset done: got %b expected 0", bus.o_done); end
    tests++; if (bus.o_data !== 16'h0) begin fails++; $display("FAIL reset data: got %h expected 0000", bus.o_data); end
    tests++; if (bus.o_alu_op !== NO_OP) begin fails++; $display("FAIL reset op: got %h expected 0", bus.o_alu_op); end
    tests++; if (bus.o_alu_arg0 !== 16'h0) begin fails++; $display("FAIL reset arg0: got %h expected 0000", bus.o_alu_arg0); end
    tests++; if (bus.o_alu_arg1 !== 16'h0) begin fails++; $display("FAIL reset arg1: got %h expected 0000", bus.o_alu_arg1); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL reset ready: got %b expected 1", bus.o_ready); end
  endtask
  task automatic test_rotate();
    run_op("rol_8001_1", 1'b0, 4'd1, 16'h8001, 16'h0003, 1, 32'h1, 0);
`ifdef ALU_SEQ_ROL8_EN
    run_op("rol_1234_12", 1'b0, 4'd12, 16'h1234, 16'h4123, 2, 32'h43, 0);
`else
    run_op("rol_1234_12", 1'b0, 4'd12, 16'h1234, 16'h4123, 3, 32'h333, 0);
`endif
  endtask
  task automatic test_shift();
    run_op("asr_8000_15", 1'b1, 4'd15, 16'h8000, 16'hFFFF, 5, 32'h77765, 0);
    run_op("asr_7f00_4", 1'b1, 4'd4, 16'h7F00, 16'h07F0, 1, 32'h7, 0);
  endtask
  task automatic test_zero();
    run_op("zero_beef", 1'b0, 4'd0, 16'hBEEF, 16'hBEEF, 0, 32'h0, 0);
  endtask
  task automatic test_back_to_back();
`ifdef ALU_SEQ_ROL8_EN
    run_op("ignore_req", 1'b0, 4'd12, 16'h1234, 16'h4123, 2, 32'h43, 2);
`else
    run_op("ignore_req", 1'b0, 4'd12, 16'h1234, 16'h4123, 3, 32'h333, 2);
`endif
    run_op("rol2_after", 1'b0, 4'd3, 16'h0001, 16'h0008, 2, 32'h21, 0);
  endtask
  task automatic test_abort();
    int dones = 0;
    bus.i_req = 1'b1; bus.i_dir = 1'b0; bus.i_amount = 4'd12; bus.i_data = 16'h1234;
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    if (bus.o_done === 1'b1) dones++;
    @(posedge clk); #1;
    if (bus.o_done === 1'b1) dones++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    if (bus.o_done === 1'b1) dones++;
    tests++; if (bus.o_data !== 16'h0) begin fails++; $display("FAIL abort data: got %h expected 0000", bus.o_data); end
    tests++; if (bus.o_alu_op !== NO_OP) begin fails++; $display("FAIL abort op: got %h expected 0", bus.o_alu_op); end
    tests++; if (bus.o_alu_arg0 !== 16'h0) begin fails++; $display("FAIL abort arg0: got %h expected 0000", bus.o_alu_arg0); end
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (bus.o_done === 1'b1) dones++;
    end
    tests++; if (dones !== 0) begin fails++; $display("FAIL abort done_pulses: got %0d expected 0", dones); end
    tests++; if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL abort ready: got %b expected 1", bus.o_ready); end
    run_op("after_abort", 1'b0, 4'd1, 16'h8001, 16'h0003, 1, 32'h1, 0);
  endtask
  initial begin
    bus.i_req = 1'b0; bus.i_dir = 1'b0; bus.i_amount = 4'd0; bus.i_data = 16'h0;
    test_reset();
    test_rotate();
    test_shift();
    test_zero();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, sets the bits per data element; WIDTH SHALL be at least 16.
REQ-002 Parameter AMT_W, default 4, sets the shift-amount width; AMT_W SHALL equal log2(WIDTH).
REQ-003 i_clk  in  1  system clock; all state SHALL change on its rising edge only.
REQ-004 i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_req  in  1  request valid; accepted only when o_ready=1.
REQ-006 i_dir  in  1  request kind: 0=rotate-left, 1=arithmetic-shift-right.
REQ-007 i_amount  in  AMT_W  shift/rotate distance, 0..WIDTH-1.
REQ-008 i_data  in  WIDTH  operand.
REQ-009 o_ready  out  1  high only in IDLE.
REQ-010 o_done  out  1  one-cycle pulse when o_data holds a new result.
REQ-011 o_data  out  WIDTH  result, held until the next accepted request.
REQ-012 o_alu_op  out  4  operation code presented to the ALU, using the codes defined in alu_ops.vh.
REQ-013 o_alu_arg0  out  WIDTH  ALU left operand; o_alu_arg1 out WIDTH, tied to 0.
REQ-014 i_alu_data  in  WIDTH  ALU result, registered by the ALU one cycle after op/arg are presented.

Function
REQ-015 The block SHALL implement the FSM IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
REQ-016 Accept rule: when i_req=1 and the FSM is in IDLE at cycle T0, the block SHALL load r_data=i_data, r_rem=i_amount and r_dir=i_dir.
REQ-017 On accept with i_amount=0, the FSM SHALL go to DONE; o_done=1 and o_data=i_data at T1.
REQ-018 Step selection for rotate: the largest of 8/4/2/1 not exceeding r_rem, giving ROL8_OP/ROL4_OP/ROL2_OP/ROL_OP.
REQ-019 Step selection for shift: the largest of 4/2/1 not exceeding r_rem, giving ASR4_OP/ASR2_OP/ASR_OP.
REQ-020 In ISSUE, o_alu_op SHALL be the selected step op and o_alu_arg0 SHALL be r_data.
REQ-021 In WAIT, the block SHALL set r_data=i_alu_data and r_rem=r_rem-step.
REQ-022 From WAIT, the FSM SHALL go to DONE if the new r_rem=0, else to ISSUE.
REQ-023 Each step SHALL take exactly 2 cycles; for k steps, o_done SHALL be high at T(2k+1) and o_ready SHALL be high again at T(2k+2).
REQ-024 In every state other than ISSUE, o_alu_op SHALL be NO_OP and o_alu_arg0 SHALL be r_data.
REQ-025 In DONE, o_data SHALL be updated from r_data; o_data SHALL be unchanged in all other states.
REQ-026 i_req while o_ready=0 SHALL be ignored, with no queuing; input changes mid-operation SHALL have no effect.
REQ-027 i_amount SHALL be taken modulo WIDTH, so no out-of-range state can arise.

Reset
REQ-028 While i_rst_n=0 at a clock edge, the FSM SHALL go to IDLE and r_data, r_rem, o_data, o_done, o_alu_op and o_alu_arg0 SHALL become 0.
REQ-029 o_ready SHALL be 1 on the first cycle after reset release.
REQ-030 Reset during ISSUE or WAIT SHALL abort the operation with no o_done pulse; the next request SHALL behave as if from power-up.

Configuration
REQ-031 Macro ALU_SEQ_ROL8_EN: when defined, rotate SHALL use ROL8_OP steps.
REQ-032 When ALU_SEQ_ROL8_EN is undefined, ROL8_OP SHALL never be issued; the rotate maximum step SHALL be 4, for ALUs built without ROL8.

Verification
REQ-033 WIDTH=16: ROL 0x8001 by 1 accepted at T0 -> one ROL_OP issue, o_done at T3, o_data=0x0003.
REQ-034 ROL 0x1234 by 12 -> with ALU_SEQ_ROL8_EN: ROL8_OP then ROL4_OP, o_done at T5; without it: three ROL4_OP, o_done at T7; o_data=0x4123 in both cases.
REQ-035 ASR 0x8000 by 15 -> ASR4_OP x3, ASR2_OP, ASR_OP, o_done at T11, o_data=0xFFFF; ASR 0x7F00 by 4 -> o_data=0x07F0, o_done at T3.
REQ-036 Amount 0, i_data=0xBEEF -> o_done at T1, o_data=0xBEEF, o_alu_op=NO_OP throughout.
REQ-037 Second i_req pulsed at T2 of an active ROL-by-12 -> ignored, exactly one o_done; i_rst_n=0 at T2 -> no o_done, all outputs 0, o_ready=1 after release.
